// File: rtl/mode_pkg.sv
// Shared encodings for the mode-select path and the blink-code indicator.
// Mode constants are also used by the mode-select block.
package mode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_e;

  localparam logic [1:0] MODE_0       = 2'd0;
  localparam logic [1:0] MODE_1       = 2'd1;
  localparam logic [1:0] MODE_2       = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

endpackage

// File: rtl/blink_interval_timer.sv
// Phase interval counter: counts up from zero after a clear and flags
// the cycle on which the count reaches term-1.
module blink_interval_timer #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == (term - WIDTH'(1)));

endmodule

// File: rtl/mode_blink_indicator.sv
// Shows the current mode on one LED as (mode+1) blinks then a long pause,
// restarting the code from its first blink whenever the mode changes.
module mode_blink_indicator
  import mode_pkg::*;
#(
  parameter int ON_TICKS  = 20000000,
  parameter int OFF_TICKS = 20000000,
  parameter int GAP_TICKS = 80000000,
  parameter int WIDTH     = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       led,
  output logic       code_done,
  output logic [1:0] blink_idx
);

  localparam logic [WIDTH-1:0] ON_T  = WIDTH'(ON_TICKS);
  localparam logic [WIDTH-1:0] OFF_T = WIDTH'(OFF_TICKS);
  localparam logic [WIDTH-1:0] GAP_T = WIDTH'(GAP_TICKS);

  blink_state_e     state_q, state_d;
  logic [1:0]       mode_q;
  logic [1:0]       idx_q, idx_d;
  logic             led_q, led_d;
  logic             vld_q;
  logic             chg;
  logic             tc;
  logic             clear;
  logic [WIDTH-1:0] term;

  // vld_q holds the FSM in IDLE until mode_q has captured a real sample.
  assign chg = vld_q && (mode != mode_q);

  always_comb begin
    term = ON_T;
    case (state_q)
      OFF:     term = OFF_T;
      GAP:     term = GAP_T;
      default: term = ON_T;
    endcase
  end

  assign clear = (state_q == IDLE) || tc || chg;

  blink_interval_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .term (term),
    .tc   (tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    code_done = 1'b0;
    if (!vld_q) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else if (chg) begin
      state_d = (mode == MODE_ILLEGAL) ? IDLE : ON;
      idx_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mode_q != MODE_ILLEGAL) begin
            state_d = ON;
            idx_d   = 2'd0;
          end
        end
        ON: begin
          if (tc) begin
            state_d = (idx_q == mode_q) ? GAP : OFF;
          end
        end
        OFF: begin
          if (tc) begin
            state_d = ON;
            idx_d   = idx_q + 2'd1;
          end
        end
        GAP: begin
          if (tc) begin
            state_d   = ON;
            idx_d     = 2'd0;
            code_done = !rst;
          end
        end
      endcase
    end
    led_d = (state_d == ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_0;
      idx_q   <= 2'd0;
      led_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      idx_q   <= idx_d;
      led_q   <= led_d;
      vld_q   <= 1'b1;
    end
  end

  assign led       = led_q;
  assign blink_idx = idx_q;

endmodule

// File: tb/tb_mode_blink_indicator.sv
// Directed bench for mode_blink_indicator with short phase lengths.
module tb_mode_blink_indicator;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int GAP = 10;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       led;
  logic       code_done;
  logic [1:0] blink_idx;

  int n_cmp = 0;
  int n_err = 0;

  mode_blink_indicator #(
    .ON_TICKS (ON),
    .OFF_TICKS(OFF),
    .GAP_TICKS(GAP),
    .WIDTH    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .led      (led),
    .code_done(code_done),
    .blink_idx(blink_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs at cycle k of an n-blink code (k=0 is first ON cycle).
  function automatic void exp_at(input int n, input int k, output logic l,
                                 output logic cd, output logic [1:0] idx);
    int per;
    int p;
    per = n * ON + (n - 1) * OFF + GAP;
    p   = k % per;
    l   = 1'b0;
    cd  = (p == per - 1);
    idx = 2'(n - 1);
    for (int j = 0; j < n; j++) begin
      int s;
      s = j * (ON + OFF);
      if (p >= s && p < s + ON) begin
        l   = 1'b1;
        idx = 2'(j);
      end else if (j < n - 1 && p >= s + ON && p < s + ON + OFF) begin
        idx = 2'(j);
      end
    end
  endfunction

  task automatic run(input int n, input int cnt, input string tag);
    logic       l;
    logic       cd;
    logic [1:0] idx;
    for (int k = 0; k < cnt; k++) begin
      exp_at(n, k, l, cd, idx);
      check({tag, "_led"}, 32'(led), 32'(l));
      check({tag, "_done"}, 32'(code_done), 32'(cd));
      check({tag, "_idx"}, 32'(blink_idx), 32'(idx));
      tick();
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    tick();
    tick();
    tick();
    check("rst_led", 32'(led), 32'd0);
    check("rst_done", 32'(code_done), 32'd0);
    check("rst_idx", 32'(blink_idx), 32'd0);

    // mode 0 after reset: first blink on the 2nd edge
    rst = 1'b0;
    tick();
    check("lat_e0_led", 32'(led), 32'd0);
    tick();
    run(1, 28, "m0");

    // mode 2 held, two full periods
    mode = 2'd2;
    tick();
    run(3, 56, "m2");

    // mode 1 -> 2 during the 2nd OFF cycle
    mode = 2'd1;
    tick();
    run(2, 5, "m1a");
    check("m1a_off2_led", 32'(led), 32'd0);
    mode = 2'd2;
    tick();
    run(3, 30, "m12");

    // illegal mode applied mid-ON
    mode = 2'd3;
    tick();
    for (int i = 0; i < 50; i++) begin
      check("m3_led", 32'(led), 32'd0);
      check("m3_done", 32'(code_done), 32'd0);
      tick();
    end
    mode = 2'd0;
    tick();
    run(1, 14, "m30");

    // reset for one cycle mid-GAP
    mode = 2'd1;
    tick();
    run(2, 15, "m1b");
    rst = 1'b1;
    tick();
    check("rst2_led", 32'(led), 32'd0);
    check("rst2_done", 32'(code_done), 32'd0);
    check("rst2_idx", 32'(blink_idx), 32'd0);
    rst = 1'b0;
    tick();
    check("rst2_e0_led", 32'(led), 32'd0);
    tick();
    run(2, 20, "m1c");

    // mode change on the GAP terminal cycle
    check("tc_nominal_done", 32'(code_done), 32'd1);
    mode = 2'd2;
    #1;
    check("tc_chg_done", 32'(code_done), 32'd0);
    tick();
    run(3, 28, "m2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
